// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder family.
// Holds the default operand width, a container type for the full sum
// including its carry, and the signed-overflow helper.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Full result of a default-width add: carry out in the top bit, sum below.
  typedef logic [DEFAULT_WIDTH:0] sum_t;

  // Two's-complement overflow: the carry entering the MSB disagrees with the
  // carry leaving it.
  function automatic logic calc_ovf(input logic carryIntoMsb,
                                    input logic carryOutOfMsb);
    return carryIntoMsb ^ carryOutOfMsb;
  endfunction

endpackage

// File: rtl/full_adder_1bit_bh.sv
// Behavioural single-bit full adder, the building block of the ripple chain.
module full_adder_1bit_bh (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/full_adder_4bit_bh.sv
// Registered WIDTH-bit ripple-carry adder with carry in/out, valid
// qualification and registered signed-overflow and zero flags.
// The sum is built combinationally from the live operands and captured on
// the next rising clock, giving a fixed one-cycle latency at full throughput.
module full_adder_4bit_bh
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid,
  output logic             ovf,
  output logic             zero
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  // One full adder per bit, each feeding its carry to the next bit up.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ripple
    full_adder_1bit_bh u_fa (
      .a    (a[g]),
      .b    (b[g]),
      .cin  (w_carry[g]),
      .s    (w_sum[g]),
      .cout (w_carry[g+1])
    );
  end

  // Capture result and flags on valid cycles; hold them otherwise. Reset
  // takes priority over a simultaneous valid so those operands are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_sum;
        r_cout <= w_carry[WIDTH];
        r_ovf  <= calc_ovf(w_carry[WIDTH-1], w_carry[WIDTH]);
        r_zero <= (w_sum == '0);
      end
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_full_adder_4bit_bh.sv
// Self-checking bench for full_adder_4bit_bh at the default 4-bit width.
// Expected results are produced by an arithmetic reference model, queued when
// operands are driven and popped when the registered result appears.
module tb_full_adder_4bit_bh;
  import adder_pkg::*;

  typedef struct packed {
    logic       cout;
    logic [3:0] s;
    logic       ovf;
    logic       zero;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic [3:0] s;
  logic       cout;
  logic       out_valid;
  logic       ovf;
  logic       zero;

  int   checks = 0;
  int   errors = 0;
  res_t expQ[$];

  full_adder_4bit_bh #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid),
    .ovf       (ovf),
    .zero      (zero)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer add, signed overflow from operand/result signs.
  function automatic res_t model(input logic [3:0] ma, input logic [3:0] mb,
                                 input logic mcin);
    sum_t full;
    res_t r;
    full   = {1'b0, ma} + {1'b0, mb} + {4'b0, mcin};
    r.cout = full[4];
    r.s    = full[3:0];
    r.ovf  = (ma[3] == mb[3]) && (full[3] != ma[3]);
    r.zero = (full[3:0] == 4'b0000);
    return r;
  endfunction

  // Drive one cycle of inputs, queue the expected result if it will be
  // accepted, then step to just after the capturing edge.
  task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb,
                               input logic vcin, input logic vvalid,
                               input logic vrstn);
    a        = va;
    b        = vb;
    cin      = vcin;
    in_valid = vvalid;
    rst_n    = vrstn;
    if (vvalid && vrstn) expQ.push_back(model(va, vb, vcin));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b1010, 4'b0101, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, cout, s, ovf, zero} !== 8'b0) begin
        errors++;
        $display("[TB] FAIL reset_state cycle=%0d got valid=%b cout=%b s=%b ovf=%b zero=%b exp all 0",
                 i, out_valid, cout, s, ovf, zero);
      end
    end
  endtask

  task automatic test_exhaustive();
    res_t exp;
    logic [3:0] va, vb;
    logic vc;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          va = ia[3:0];
          vb = ib[3:0];
          vc = ic[0];
          applyStimulus(va, vb, vc, 1'b1, 1'b1);
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exh_valid a=%0d b=%0d cin=%0d got=%b exp=1",
                     va, vb, vc, out_valid);
          end
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL exh_queue a=%0d b=%0d cin=%0d got empty exp entry", va, vb, vc);
          end else begin
            exp = expQ.pop_front();
            if ({cout, s, ovf, zero} !== exp) begin
              errors++;
              $display("[TB] FAIL exh_result a=%0d b=%0d cin=%0d got cout=%b s=%b ovf=%b zero=%b exp cout=%b s=%b ovf=%b zero=%b",
                       va, vb, vc, cout, s, ovf, zero, exp.cout, exp.s, exp.ovf, exp.zero);
            end
          end
        end
      end
    end
  endtask

  // Corner vectors with hand-derived results, also cross-checked against
  // the scoreboard entry.
  task automatic test_corners();
    logic [3:0] ta [7];
    logic [3:0] tb [7];
    logic       tc [7];
    res_t       tr [7];
    res_t       exp;
    ta = '{4'b1111, 4'b0000, 4'b1111, 4'b0111, 4'b1000, 4'b0011, 4'b1000};
    tb = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b0010, 4'b1000};
    tc = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};
    tr = '{7'b1_1111_0_0, 7'b0_0000_0_1, 7'b1_0000_0_1, 7'b0_1000_1_0,
           7'b1_0111_1_0, 7'b0_0101_0_0, 7'b1_0000_1_1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(ta[i], tb[i], tc[i], 1'b1, 1'b1);
      checks++;
      if ({out_valid, cout, s, ovf, zero} !== {1'b1, tr[i]}) begin
        errors++;
        $display("[TB] FAIL corner_%0d got valid=%b cout=%b s=%b ovf=%b zero=%b exp valid=1 cout=%b s=%b ovf=%b zero=%b",
                 i, out_valid, cout, s, ovf, zero, tr[i].cout, tr[i].s, tr[i].ovf, tr[i].zero);
      end
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL corner_queue_%0d got empty exp entry", i);
      end else begin
        exp = expQ.pop_front();
        if ({cout, s, ovf, zero} !== exp) begin
          errors++;
          $display("[TB] FAIL corner_model_%0d got %b exp %b", i, {cout, s, ovf, zero}, exp);
        end
      end
    end
  endtask

  task automatic test_valid_gating();
    res_t exp;
    applyStimulus(4'b0011, 4'b0100, 1'b1, 1'b1, 1'b1);
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL gate_queue got empty exp entry");
    end else begin
      exp = expQ.pop_front();
      if ({out_valid, cout, s, ovf, zero} !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL gate_accept got valid=%b res=%b exp valid=1 res=%b",
                 out_valid, {cout, s, ovf, zero}, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({out_valid, cout, s, ovf, zero} !== {1'b0, 1'b0, 4'b1000, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL gate_hold cycle=%0d got valid=%b cout=%b s=%b ovf=%b zero=%b exp valid=0 cout=0 s=1000 ovf=1 zero=0",
                 i, out_valid, cout, s, ovf, zero);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    res_t exp;
    applyStimulus(4'b0101, 4'b0110, 1'b0, 1'b1, 1'b1);
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL mid_queue got empty exp entry");
    end else begin
      exp = expQ.pop_front();
      if ({out_valid, cout, s, ovf, zero} !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL mid_first got valid=%b res=%b exp valid=1 res=%b",
                 out_valid, {cout, s, ovf, zero}, exp);
      end
    end
    applyStimulus(4'b1001, 4'b0011, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({out_valid, cout, s, ovf, zero} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got valid=%b cout=%b s=%b ovf=%b zero=%b exp all 0",
               out_valid, cout, s, ovf, zero);
    end
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({out_valid, cout, s, ovf, zero} !== {1'b1, 1'b0, 4'b0010, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_release got valid=%b cout=%b s=%b ovf=%b zero=%b exp valid=1 cout=0 s=0010 ovf=0 zero=0",
               out_valid, cout, s, ovf, zero);
    end
    if (expQ.size() != 0) void'(expQ.pop_front());
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    test_reset();
    test_exhaustive();
    test_corners();
    test_valid_gating();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
